// File: rtl/eth_udp_rx_parser_pkg.sv
// Shared definitions for the Ethernet/IPv4/UDP receive parser: header byte
// offsets (0 = first destination-MAC byte), protocol constants, FSM states
// and a byte-select helper used by the header filter.
package eth_udp_rx_parser_pkg;

   localparam logic [5:0]  PAYLOAD_OFS    = 6'd42;
   localparam logic [5:0]  HDR_LAST_OFS   = PAYLOAD_OFS - 6'd1;
   localparam logic [5:0]  ETH_DST_OFS    = 6'd0;
   localparam logic [5:0]  ETH_DST_LAST   = 6'd5;
   localparam logic [5:0]  ETH_TYPE_OFS   = 6'd12;
   localparam logic [5:0]  IP_VER_IHL_OFS = 6'd14;
   localparam logic [5:0]  IP_PROTO_OFS   = 6'd23;
   localparam logic [5:0]  IP_DST_OFS     = 6'd30;
   localparam logic [5:0]  UDP_DPORT_OFS  = 6'd36;
   localparam logic [5:0]  UDP_LEN_OFS    = 6'd38;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
   localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DRAIN   = 2'd3
   } rx_state_e;

   // Byte idx of a 48-bit value, counted from the most significant byte.
   function automatic logic [7:0] sel_byte(input logic [47:0] v, input logic [2:0] idx);
      logic [47:0] shifted;
      shifted = v << {idx, 3'b000};
      return shifted[47:40];
   endfunction

endpackage

// File: rtl/eth_udp_rx_parser_hdr_filter.sv
// Header filter: compares each header byte against the expected field on the
// cycle it arrives, keeps a running match flag for the frame, and captures the
// UDP length (high byte registered, low byte taken live on its own cycle).
module eth_hdr_filter
   import eth_udp_rx_parser_pkg::*;
#(
   parameter logic [47:0] MAC_ADDR  = 48'h01005E000001,
   parameter bit          CHECK_MAC = 1'b1,
   parameter logic [31:0] IP_ADDR   = 32'hE9360C6F,
   parameter logic [15:0] UDP_PORT  = 16'd26400
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_byte_en,
   input  logic [5:0]  i_ofs,
   input  logic [7:0]  i_data,
   output logic        o_match,
   output logic [15:0] o_udp_len
);

   logic       r_match;
   logic [7:0] r_len_hi;
   logic       w_byte_ok;
   logic       w_match_base;

   // Per-byte field check selected by the header offset.
   always_comb begin
      w_byte_ok = 1'b1;
      if (i_ofs <= ETH_DST_LAST) begin
         w_byte_ok = !CHECK_MAC || (i_data == sel_byte(MAC_ADDR, i_ofs[2:0]));
      end else if (i_ofs == ETH_TYPE_OFS) begin
         w_byte_ok = (i_data == ETHERTYPE_IPV4[15:8]);
      end else if (i_ofs == ETH_TYPE_OFS + 6'd1) begin
         w_byte_ok = (i_data == ETHERTYPE_IPV4[7:0]);
      end else if (i_ofs == IP_VER_IHL_OFS) begin
         w_byte_ok = (i_data == IP_VER_IHL);
      end else if (i_ofs == IP_PROTO_OFS) begin
         w_byte_ok = (i_data == IP_PROTO_UDP);
      end else if ((i_ofs >= IP_DST_OFS) && (i_ofs <= IP_DST_OFS + 6'd3)) begin
         w_byte_ok = (i_data == sel_byte({IP_ADDR, 16'h0000}, 3'(i_ofs - IP_DST_OFS)));
      end else if ((i_ofs >= UDP_DPORT_OFS) && (i_ofs <= UDP_DPORT_OFS + 6'd1)) begin
         w_byte_ok = (i_data == sel_byte({UDP_PORT, 32'h0000_0000}, 3'(i_ofs - UDP_DPORT_OFS)));
      end else begin
         w_byte_ok = 1'b1;
      end
   end

   // The first header byte starts a fresh match; later bytes can only clear it.
   assign w_match_base = (i_ofs == ETH_DST_OFS) ? 1'b1 : r_match;

   // Running match flag and UDP length high byte.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_match  <= 1'b0;
         r_len_hi <= 8'h00;
      end else if (i_byte_en) begin
         r_match <= w_match_base & w_byte_ok;
         if (i_ofs == UDP_LEN_OFS) begin
            r_len_hi <= i_data;
         end
      end
   end

   assign o_match   = r_match;
   assign o_udp_len = {r_len_hi, i_data};

endmodule

// File: rtl/eth_udp_rx_parser.sv
// Ethernet II / IPv4 / UDP receive parser. Filters on destination MAC, IP and
// UDP port and forwards only the UDP payload with first/last framing, one
// register stage after the input byte. Counts rejected frames (saturating).
module eth_udp_rx_parser
   import eth_udp_rx_parser_pkg::*;
#(
   parameter logic [47:0] MAC_ADDR  = 48'h01005E000001,
   parameter bit          CHECK_MAC = 1'b1,
   parameter logic [31:0] IP_ADDR   = 32'hE9360C6F,
   parameter logic [15:0] UDP_PORT  = 16'd26400
)(
   input  logic        rxClkIn,
   input  logic        rstIn,
   input  logic [7:0]  rxDataIn,
   input  logic        rxDataValidIn,
   input  logic        rxDataLastIn,
   output logic [7:0]  payloadDataOut,
   output logic        payloadValidOut,
   output logic        payloadFirstOut,
   output logic        payloadLastOut,
   output logic [15:0] payloadLenOut,
   output logic        truncErrOut,
   output logic        frameDropOut,
   output logic [15:0] dropCntOut
);

   rx_state_e   r_state, w_state_nxt;
   logic [5:0]  r_hdr_cnt, w_hdr_cnt_nxt;
   logic [15:0] r_pay_cnt, w_pay_cnt_nxt;
   logic [7:0]  r_data, w_data_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_first, w_first_nxt;
   logic        r_last, w_last_nxt;
   logic [15:0] r_len, w_len_nxt;
   logic        r_trunc, w_trunc_nxt;
   logic        r_drop, w_drop_nxt;
   logic [15:0] r_drop_cnt, w_drop_cnt_nxt;

   logic        w_hdr_en;
   logic [5:0]  w_hdr_ofs;
   logic        w_match;
   logic [15:0] w_udp_len;
   logic [15:0] w_last_idx;
   logic        w_at_end;

   // In IDLE the arriving byte is header offset 0.
   assign w_hdr_ofs  = (r_state == ST_IDLE) ? ETH_DST_OFS : r_hdr_cnt;
   assign w_hdr_en   = rxDataValidIn && ((r_state == ST_IDLE) || (r_state == ST_HDR));
   assign w_last_idx = r_len - 16'd1;
   assign w_at_end   = (r_pay_cnt == w_last_idx);

   eth_hdr_filter #(
      .MAC_ADDR  (MAC_ADDR),
      .CHECK_MAC (CHECK_MAC),
      .IP_ADDR   (IP_ADDR),
      .UDP_PORT  (UDP_PORT)
   ) u_hdr_filter (
      .i_clk     (rxClkIn),
      .i_rst_n   (rstIn),
      .i_byte_en (w_hdr_en),
      .i_ofs     (w_hdr_ofs),
      .i_data    (rxDataIn),
      .o_match   (w_match),
      .o_udp_len (w_udp_len)
   );

   // Next-state, counters and next output values.
   always_comb begin
      w_state_nxt   = r_state;
      w_hdr_cnt_nxt = r_hdr_cnt;
      w_pay_cnt_nxt = r_pay_cnt;
      w_data_nxt    = 8'h00;
      w_valid_nxt   = 1'b0;
      w_first_nxt   = 1'b0;
      w_last_nxt    = 1'b0;
      w_len_nxt     = r_len;
      w_trunc_nxt   = 1'b0;
      w_drop_nxt    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (rxDataValidIn) begin
               w_hdr_cnt_nxt = 6'd1;
               if (rxDataLastIn) begin
                  w_drop_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_HDR;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (rxDataValidIn) begin
               w_hdr_cnt_nxt = r_hdr_cnt + 6'd1;
               if (r_hdr_cnt == UDP_LEN_OFS + 6'd1) begin
                  if (w_udp_len < UDP_HDR_LEN) begin
                     w_drop_nxt  = 1'b1;
                     w_state_nxt = rxDataLastIn ? ST_IDLE : ST_DRAIN;
                  end else if (w_udp_len == UDP_HDR_LEN) begin
                     // Empty datagram: nothing to forward, not a rejection.
                     w_state_nxt = rxDataLastIn ? ST_IDLE : ST_DRAIN;
                  end else begin
                     w_len_nxt = w_udp_len - UDP_HDR_LEN;
                     if (rxDataLastIn) begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                     end else begin
                        w_state_nxt = ST_HDR;
                     end
                  end
               end else if (r_hdr_cnt == HDR_LAST_OFS) begin
                  if (!w_match) begin
                     w_drop_nxt  = 1'b1;
                     w_state_nxt = rxDataLastIn ? ST_IDLE : ST_DRAIN;
                  end else if (rxDataLastIn) begin
                     // Accepted header but the frame carries no payload at all.
                     w_trunc_nxt = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_pay_cnt_nxt = 16'd0;
                     w_state_nxt   = ST_PAYLOAD;
                  end
               end else if (rxDataLastIn) begin
                  w_drop_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_HDR;
               end
            end else begin
               w_state_nxt = ST_HDR;
            end
         end
         ST_PAYLOAD: begin
            if (rxDataValidIn) begin
               w_data_nxt    = rxDataIn;
               w_valid_nxt   = 1'b1;
               w_first_nxt   = (r_pay_cnt == 16'd0);
               w_last_nxt    = w_at_end || rxDataLastIn;
               w_trunc_nxt   = rxDataLastIn && !w_at_end;
               w_pay_cnt_nxt = r_pay_cnt + 16'd1;
               if (rxDataLastIn) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_at_end) begin
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_state_nxt = ST_PAYLOAD;
               end
            end else begin
               w_state_nxt = ST_PAYLOAD;
            end
         end
         ST_DRAIN: begin
            if (rxDataValidIn && rxDataLastIn) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_drop_nxt && (r_drop_cnt != 16'hFFFF)) begin
         w_drop_cnt_nxt = r_drop_cnt + 16'd1;
      end else begin
         w_drop_cnt_nxt = r_drop_cnt;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge rxClkIn or negedge rstIn) begin
      if (!rstIn) begin
         r_state    <= ST_IDLE;
         r_hdr_cnt  <= 6'd0;
         r_pay_cnt  <= 16'd0;
         r_data     <= 8'h00;
         r_valid    <= 1'b0;
         r_first    <= 1'b0;
         r_last     <= 1'b0;
         r_len      <= 16'd0;
         r_trunc    <= 1'b0;
         r_drop     <= 1'b0;
         r_drop_cnt <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_hdr_cnt  <= w_hdr_cnt_nxt;
         r_pay_cnt  <= w_pay_cnt_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_first    <= w_first_nxt;
         r_last     <= w_last_nxt;
         r_len      <= w_len_nxt;
         r_trunc    <= w_trunc_nxt;
         r_drop     <= w_drop_nxt;
         r_drop_cnt <= w_drop_cnt_nxt;
      end
   end

   assign payloadDataOut  = r_data;
   assign payloadValidOut = r_valid;
   assign payloadFirstOut = r_first;
   assign payloadLastOut  = r_last;
   assign payloadLenOut   = r_len;
   assign truncErrOut     = r_trunc;
   assign frameDropOut    = r_drop;
   assign dropCntOut      = r_drop_cnt;

endmodule

// File: tb/tb_eth_udp_rx_parser.sv
// Randomized self-checking bench for eth_udp_rx_parser. Frames are built as
// byte arrays; a frame-level reference model derives the expected payload
// bytes (with first/last/length), drop pulses and truncation pulses.
module tb_eth_udp_rx_parser;

   localparam logic [47:0] MAC  = 48'h01005E000001;
   localparam logic [31:0] IP   = 32'hE9360C6F;
   localparam logic [15:0] PORT = 16'd26400;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_last;
   logic [7:0]  pay_data;
   logic        pay_valid, pay_first, pay_last;
   logic [15:0] pay_len;
   logic        trunc_err, frame_drop;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   eth_udp_rx_parser #(
      .MAC_ADDR(MAC), .CHECK_MAC(1'b1), .IP_ADDR(IP), .UDP_PORT(PORT)
   ) dut (
      .rxClkIn(clk), .rstIn(rst_n),
      .rxDataIn(rx_data), .rxDataValidIn(rx_valid), .rxDataLastIn(rx_last),
      .payloadDataOut(pay_data), .payloadValidOut(pay_valid),
      .payloadFirstOut(pay_first), .payloadLastOut(pay_last),
      .payloadLenOut(pay_len), .truncErrOut(trunc_err),
      .frameDropOut(frame_drop), .dropCntOut(drop_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  frame_q[$];
   logic [25:0] exp_q[$];   // {first, last, len[15:0], data[7:0]}
   logic [25:0] got_q[$];
   int exp_drop_pulses = 0;
   int exp_trunc       = 0;
   int exp_drops_total = 0;
   int mon_drop        = 0;
   int mon_trunc       = 0;
   int mon_trunc_at    = -1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Output monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (pay_valid) got_q.push_back({pay_first, pay_last, pay_len, pay_data});
      if (frame_drop) mon_drop++;
      if (trunc_err) begin
         mon_trunc++;
         if (pay_valid && pay_last) mon_trunc_at = got_q.size();
      end
   end

   task automatic drive(input logic [7:0] d, input logic v, input logic l);
      @(posedge clk);
      #1;
      rx_data  = d;
      rx_valid = v;
      rx_last  = l;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(8'h00, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input int gap_pct);
      for (int i = 0; i < frame_q.size(); i++) begin
         while (int'($urandom_range(99)) < gap_pct) drive(8'h00, 1'b0, 1'b0);
         drive(frame_q[i], 1'b1, (i == frame_q.size() - 1));
      end
   endtask

   task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] vihl,
                        input logic [7:0] proto, input logic [31:0] ip, input logic [15:0] port,
                        input logic [15:0] ulen, input int npay, input bit rnd_pay, input bit fcs);
      logic [15:0] tot;
      tot = ulen + 16'd20;
      frame_q.delete();
      for (int i = 0; i < 6; i++) frame_q.push_back(mac[47 - 8*i -: 8]);
      for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));
      frame_q.push_back(et[15:8]);  frame_q.push_back(et[7:0]);
      frame_q.push_back(vihl);      frame_q.push_back(8'h00);
      frame_q.push_back(tot[15:8]); frame_q.push_back(tot[7:0]);
      for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom));
      frame_q.push_back(8'h40);     frame_q.push_back(proto);
      for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));   // csum + src IP
      for (int i = 0; i < 4; i++) frame_q.push_back(ip[31 - 8*i -: 8]);
      frame_q.push_back(8'($urandom)); frame_q.push_back(8'($urandom));
      frame_q.push_back(port[15:8]); frame_q.push_back(port[7:0]);
      frame_q.push_back(ulen[15:8]); frame_q.push_back(ulen[7:0]);
      frame_q.push_back(8'($urandom)); frame_q.push_back(8'($urandom));
      for (int i = 0; i < npay; i++) frame_q.push_back(rnd_pay ? 8'($urandom) : 8'(i));
      if (fcs) for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom));
   endtask

   // Reference model: what a frame should produce, from the header rules.
   task automatic model_frame();
      int n, plen, avail, cnt;
      logic [15:0] ulen;
      bit ok;
      n = frame_q.size();
      if (n < 40) begin exp_drop_pulses++; exp_drops_total++; return; end
      ulen = {frame_q[38], frame_q[39]};
      if (ulen < 16'd8) begin exp_drop_pulses++; exp_drops_total++; return; end
      if (ulen == 16'd8) return;
      if (n < 42) begin exp_drop_pulses++; exp_drops_total++; return; end
      ok = ({frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]} == MAC)
        && ({frame_q[12], frame_q[13]} == 16'h0800) && (frame_q[14] == 8'h45)
        && (frame_q[23] == 8'd17)
        && ({frame_q[30], frame_q[31], frame_q[32], frame_q[33]} == IP)
        && ({frame_q[36], frame_q[37]} == PORT);
      if (!ok) begin exp_drop_pulses++; exp_drops_total++; return; end
      plen  = int'(ulen) - 8;
      avail = n - 42;
      cnt   = (avail < plen) ? avail : plen;
      if (avail < plen) exp_trunc++;
      for (int i = 0; i < cnt; i++)
         exp_q.push_back({(i == 0), (i == cnt - 1), 16'(plen), frame_q[42 + i]});
   endtask

   task automatic clear_all();
      got_q.delete(); exp_q.delete();
      mon_drop = 0; mon_trunc = 0; mon_trunc_at = -1;
      exp_drop_pulses = 0; exp_trunc = 0;
   endtask

   task automatic end_test(input string tag);
      int nerr, m;
      idle(4);
      check_eq({tag, " n_bytes"}, got_q.size(), exp_q.size());
      nerr = 0;
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) nerr++;
      check_eq({tag, " byte_mism"}, nerr, 0);
      check_eq({tag, " drop_pulses"}, mon_drop, exp_drop_pulses);
      check_eq({tag, " trunc_pulses"}, mon_trunc, exp_trunc);
      check_eq({tag, " drop_cnt"}, drop_cnt, exp_drops_total);
      clear_all();
   endtask

   initial begin
      logic [47:0] mac;
      logic [15:0] et, port, ulen;
      logic [7:0]  vihl, proto;
      logic [31:0] ip;
      int npay;
      bit fcs;

      rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ctl", {pay_valid, pay_first, pay_last, trunc_err, frame_drop, pay_data}, 0);
      check_eq("rst_cnt", {pay_len, drop_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Matching 1440-byte payload with FCS.
      build(MAC, 16'h0800, 8'h45, 8'd17, IP, PORT, 16'd1448, 1440, 1'b0, 1'b1);
      model_frame(); send_frame(0); end_test("t1_match");

      // Wrong destination port, three times.
      for (int k = 0; k < 3; k++) begin
         build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd26401, 16'd1448, 1440, 1'b0, 1'b1);
         model_frame(); send_frame(0); end_test("t2_port");
      end

      // EtherType, protocol and IHL rejections.
      build(MAC, 16'h86DD, 8'h45, 8'd17, IP, PORT, 16'd28, 20, 1'b1, 1'b1);
      model_frame(); send_frame(0); end_test("t3_etype");
      build(MAC, 16'h0800, 8'h45, 8'd6, IP, PORT, 16'd28, 20, 1'b1, 1'b1);
      model_frame(); send_frame(0); end_test("t3_proto");
      build(MAC, 16'h0800, 8'h46, 8'd17, IP, PORT, 16'd28, 20, 1'b1, 1'b1);
      model_frame(); send_frame(0); end_test("t3_ihl");

      // Truncated: UDP length 108 but only 50 payload bytes arrive.
      build(MAC, 16'h0800, 8'h45, 8'd17, IP, PORT, 16'd108, 50, 1'b1, 1'b0);
      model_frame(); send_frame(0); idle(3);
      check_eq("t4 trunc_at", mon_trunc_at, 50);
      end_test("t4_trunc");

      // Gappy frame then a back-to-back frame.
      build(MAC, 16'h0800, 8'h45, 8'd17, IP, PORT, 16'd208, 200, 1'b1, 1'b1);
      model_frame(); send_frame(30);
      build(MAC, 16'h0800, 8'h45, 8'd17, IP, PORT, 16'd72, 64, 1'b1, 1'b1);
      model_frame(); send_frame(0);
      end_test("t5_b2b");

      // Randomized frames with occasional field corruption and length corner cases.
      for (int k = 0; k < 16; k++) begin
         mac   = ($urandom_range(9) == 0) ? MAC ^ (48'h1 << $urandom_range(47)) : MAC;
         et    = ($urandom_range(9) == 0) ? 16'h86DD : 16'h0800;
         vihl  = ($urandom_range(9) == 0) ? 8'h46 : 8'h45;
         proto = ($urandom_range(9) == 0) ? 8'd6 : 8'd17;
         ip    = ($urandom_range(9) == 0) ? IP ^ (32'h1 << $urandom_range(31)) : IP;
         port  = ($urandom_range(9) == 0) ? PORT + 16'd1 : PORT;
         if ($urandom_range(9) == 0) begin
            ulen = 16'($urandom_range(8));
            npay = 6; fcs = 1'b1;
         end else begin
            ulen = 16'($urandom_range(80, 9));
            if ($urandom_range(4) == 0) begin
               npay = $urandom_range(int'(ulen) - 9); fcs = 1'b0;
            end else begin
               npay = int'(ulen) - 8; fcs = 1'b1;
            end
         end
         build(mac, et, vihl, proto, ip, port, ulen, npay, 1'b1, fcs);
         model_frame(); send_frame($urandom_range(30)); end_test("t6_rand");
      end

      // Reset while payload byte 20 is on the input.
      build(MAC, 16'h0800, 8'h45, 8'd17, IP, PORT, 16'd108, 100, 1'b0, 1'b1);
      for (int i = 0; i < 62; i++) drive(frame_q[i], 1'b1, 1'b0);
      drive(frame_q[62], 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("t7 rst_ctl", {pay_valid, pay_first, pay_last, trunc_err, frame_drop, pay_data}, 0);
      check_eq("t7 rst_cnt", {pay_len, drop_cnt}, 0);
      clear_all();
      exp_drops_total = 0;
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 63; i++) void'(frame_q.pop_front());
      model_frame(); send_frame(0);
      build(MAC, 16'h0800, 8'h45, 8'd17, IP, PORT, 16'd58, 50, 1'b1, 1'b1);
      model_frame(); send_frame(0);
      end_test("t7_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
